demux4_deserializer: RTL and testbench

- Receive-side counterpart of the 4-input bit multiplexer.
- A transmitter walks the mux select across slots 0..3 and drives one bit per step onto a serial line. This block samples that line, steers each bit into its slot, and presents the reassembled word as a parallel output with a valid/ready handshake.
- It sits between the serial link and any parallel consumer.
- It reports the current slot index and flags words lost to backpressure.

---
 rtl/demux4_deserializer.sv | 121 ++++++++++++
 tb/tb_demux4_deserializer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux4_deserializer.sv
// demux4_deserializer
//   Receive side of a WIDTH-input bit multiplexer link. The transmitter sweeps
//   its select across slots 0..WIDTH-1 and sends one bit per step. This block
//   steers each accepted serial bit into its slot of an assembly register.
//   When a word is complete it hands the word to a parallel consumer through
//   a valid/ready handshake.
//
// Parameters
//   WIDTH      bits per word (2..16), equal to the number of mux inputs
//   LSB_FIRST  1: slot k -> bit k; 0: slot k -> bit WIDTH-1-k
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   in             serial data bit
//   in_valid       in carries a bit this cycle
//   frame_start    realign; a valid bit this cycle is slot 0, and any partial
//                  word is discarded
//   out            last delivered word; it is stable while out_valid=1
//   out_valid      out holds a word that has not been consumed
//   out_ready      consumer takes out this cycle
//   select         slot that the next valid bit will fill
//   overrun        sticky flag; a completed word was dropped on backpressure
//   overrun_clear  clears overrun (a drop on the same edge takes priority)
//
// Every output comes from a register. No input has a combinational path to
// any output.
module demux4_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in,
    input  logic                     in_valid,
    input  logic                     frame_start,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] select,
    output logic                     overrun,
    input  logic                     overrun_clear
);

    localparam int            SW   = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    logic [WIDTH-1:0] asm_q;     // assembly register
    logic [WIDTH-1:0] asm_d;     // assembly with this cycle's bit merged in
    logic [SW-1:0]    slot;      // slot the current bit lands in
    logic [SW-1:0]    select_d;
    logic             complete;  // this edge accepts the last bit of a word
    logic             consume;   // consumer takes the held word this edge
    logic             load;      // completed word goes to out
    logic             drop;      // completed word is lost to backpressure

    // frame_start forces the current bit into slot 0, whatever select holds.
    assign slot = frame_start ? '0 : select;

    // Each slot owns exactly one assembly bit. The mapping is a fixed
    // permutation, so every bit has a single driver. Bits that are not
    // written keep their old value.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_slot
            localparam int POS = LSB_FIRST ? gi : (WIDTH - 1 - gi);
            assign asm_d[POS] = (in_valid && (slot == SW'(gi))) ? in : asm_q[POS];
        end
    endgenerate

    // A frame_start bit is always slot 0, so it can never finish a word
    // (WIDTH >= 2).
    assign complete = in_valid && !frame_start && (select == LAST);
    assign consume  = out_valid && out_ready;
    assign load     = complete && (!out_valid || out_ready);
    assign drop     = complete && out_valid && !out_ready;

    always_comb begin
        select_d = select;
        if (in_valid) begin
            if (frame_start)
                select_d = SW'(1);
            else if (select == LAST)
                select_d = '0;
            else
                select_d = select + SW'(1);
        end else if (frame_start) begin
            select_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q     <= '0;
            select    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            select <= select_d;

            // Loading a new word while the old one is consumed keeps
            // out_valid high, so back-to-back words have no bubble.
            if (load) begin
                out       <= asm_d;
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end

            // A drop on the same edge as a clear wins, so no loss goes
            // unreported.
            if (drop)
                overrun <= 1'b1;
            else if (overrun_clear)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux4_deserializer.sv
// Testbench for demux4_deserializer. Two instances share the same serial
// stimulus. dut_l uses LSB_FIRST=1 and dut_m uses LSB_FIRST=0. Expected words
// are pushed into a per-instance queue when the stimulus is issued. A monitor
// pops from the queue and compares whenever a word is handed over
// (out_valid && out_ready). Control and status outputs are checked directly,
// #1 after the rising edge.
module tb_demux4_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in, in_valid, frame_start, out_ready, overrun_clear;
    logic [3:0] out_l, out_m;
    logic       ov_l, ov_m;          // out_valid
    logic [1:0] sel_l, sel_m;
    logic       orun_l, orun_m;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] q_l[$];
    logic [3:0] q_m[$];

    always #5 clk = ~clk;

    demux4_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .frame_start(frame_start), .out(out_l), .out_valid(ov_l),
        .out_ready(out_ready), .select(sel_l), .overrun(orun_l),
        .overrun_clear(overrun_clear));

    demux4_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .frame_start(frame_start), .out(out_m), .out_valid(ov_m),
        .out_ready(out_ready), .select(sel_m), .overrun(orun_m),
        .overrun_clear(overrun_clear));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The monitor samples at the falling edge, midway between input changes.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_ready === 1'b1) begin
            if (ov_l === 1'b1) begin
                if (q_l.size() == 0) chk("l_spurious_word", {28'd0, out_l}, 32'hdead);
                else chk("l_word", {28'd0, out_l}, {28'd0, q_l.pop_front()});
            end
            if (ov_m === 1'b1) begin
                if (q_m.size() == 0) chk("m_spurious_word", {28'd0, out_m}, 32'hdead);
                else chk("m_word", {28'd0, out_m}, {28'd0, q_m.pop_front()});
            end
        end
    end

    // One clock: drive inputs, take the edge, and settle 1 time unit past it.
    task automatic cyc(input logic v, input logic b, input logic fs);
        in_valid = v; in = b; frame_start = fs;
        @(posedge clk); #1;
        in_valid = 1'b0; in = 1'b0; frame_start = 1'b0;
    endtask

    // seq[3] is sent first.
    task automatic send4(input logic [3:0] seq);
        for (int i = 3; i >= 0; i--) cyc(1'b1, seq[i], 1'b0);
    endtask

    task automatic chk_sel(input string name, input logic [1:0] exp);
        chk({name, "_l"}, {30'd0, sel_l}, {30'd0, exp});
        chk({name, "_m"}, {30'd0, sel_m}, {30'd0, exp});
    endtask

    task automatic chk_flags(input string name, input logic v, input logic o);
        chk({name, "_vld_l"}, {31'd0, ov_l}, {31'd0, v});
        chk({name, "_vld_m"}, {31'd0, ov_m}, {31'd0, v});
        chk({name, "_ovr_l"}, {31'd0, orun_l}, {31'd0, o});
        chk({name, "_ovr_m"}, {31'd0, orun_m}, {31'd0, o});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        logic [3:0] seq;
        reset = 1'b1; in = 1'b0; in_valid = 1'b0; frame_start = 1'b0;
        out_ready = 1'b1; overrun_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk_sel("rst_sel", 2'd0);
        chk_flags("rst", 1'b0, 1'b0);
        chk("rst_out_l", {28'd0, out_l}, 32'd0);
        chk("rst_out_m", {28'd0, out_m}, 32'd0);

        // Basic word 0,1,1,0 -> 0110 for both mappings; select walks 0..3,0
        q_l.push_back(4'b0110); q_m.push_back(4'b0110);
        seq = 4'b0110;
        for (int i = 3; i >= 0; i--) begin
            chk_sel("walk_sel", 2'(3 - i));
            cyc(1'b1, seq[i], 1'b0);
        end
        chk_sel("walk_wrap", 2'd0);
        chk_flags("walk_done", 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk_flags("walk_taken", 1'b0, 1'b0);

        // 1,0,0,0 -> LSB 0001, MSB 1000
        q_l.push_back(4'b0001); q_m.push_back(4'b1000);
        send4(4'b1000);
        cyc(1'b0, 1'b0, 1'b0);

        // Gapped 1,0,1,1: select holds through the gaps -> LSB 1101, MSB 1011
        q_l.push_back(4'b1101); q_m.push_back(4'b1011);
        seq = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            cyc(1'b1, seq[i], 1'b0);
            if (i > 0) begin
                repeat (2) cyc(1'b0, 1'b1, 1'b0);
                chk_sel("gap_hold", 2'(4 - i));
                chk_flags("gap_novld", 1'b0, 1'b0);
            end
        end
        chk_flags("gap_done", 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // Backpressure: LSB words 1010 (kept) and 0101 (dropped)
        out_ready = 1'b0;
        q_l.push_back(4'b1010); q_m.push_back(4'b0101);
        send4(4'b0101);
        chk_flags("bp_first", 1'b1, 1'b0);
        send4(4'b1010);
        chk_flags("bp_drop", 1'b1, 1'b1);
        chk("bp_hold_l", {28'd0, out_l}, 32'h a);
        overrun_clear = 1'b1; cyc(1'b0, 1'b0, 1'b0); overrun_clear = 1'b0;
        chk_flags("bp_clear", 1'b1, 1'b0);
        // Back-to-back: 0011 completes on the same edge that 1010 is taken
        q_l.push_back(4'b0011); q_m.push_back(4'b1100);
        cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        chk_flags("b2b_stay", 1'b1, 1'b0);
        chk("b2b_out_l", {28'd0, out_l}, 32'h3);
        cyc(1'b0, 1'b0, 1'b0);
        chk_flags("b2b_taken", 1'b0, 1'b0);

        // Realign with frame_start and in_valid=0: the partial 1,1 is discarded
        cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk_sel("fs_idle_sel", 2'd0);
        chk_flags("fs_idle", 1'b0, 1'b0);
        q_l.push_back(4'b0010); q_m.push_back(4'b0100);
        send4(4'b0100);
        cyc(1'b0, 1'b0, 1'b0);
        chk_flags("fs_word", 1'b0, 1'b0);
        // frame_start with a valid bit after 3 bits: that bit becomes slot 0
        cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk_sel("fs_valid_sel", 2'd1);
        chk_flags("fs_valid_nocmp", 1'b0, 1'b0);
        q_l.push_back(4'b1001); q_m.push_back(4'b1001);
        cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // Set and clear on the same edge keep overrun high
        out_ready = 1'b0;
        send4(4'b1011);                 // held, never consumed before reset
        cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
        overrun_clear = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);          // drop and clear on the same edge
        overrun_clear = 1'b0;
        chk_flags("setclr", 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0);
        chk_sel("pre_rst_sel", 2'd2);

        // Async reset between edges clears everything at once
        #2 reset = 1'b1;
        #1;
        chk_sel("arst_sel", 2'd0);
        chk_flags("arst", 1'b0, 1'b0);
        chk("arst_out_l", {28'd0, out_l}, 32'd0);
        chk("arst_out_m", {28'd0, out_m}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        out_ready = 1'b1;
        q_l.push_back(4'b1111); q_m.push_back(4'b1111);
        send4(4'b1111);
        chk_flags("post_rst", 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        chk("q_l_empty", q_l.size(), 32'd0);
        chk("q_m_empty", q_m.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
